// File: rtl/mlp_pkg.sv
// mlp_pkg: shared sizes, FSM state encoding and operand slot indices for the
// MLP operand loader.
// Latency: n/a (declarations only). Backpressure: n/a.
package mlp_pkg;

   localparam int DW      = 2;    // operand width
   localparam int NUM_OPS = 11;   // operands per frame
   localparam int CNT_W   = 8;    // statistics counter width

   typedef enum logic [1:0] {
      LOAD  = 2'd0,   // collecting words of a frame
      HOLD  = 2'd1,   // complete frame presented to the MLP
      DRAIN = 2'd2    // discarding the tail of an over-long frame
   } state_t;

   // Slot of each operand within a frame, in wire order.
   localparam int IDX_X0  = 0;
   localparam int IDX_X1  = 1;
   localparam int IDX_W00 = 2;
   localparam int IDX_W01 = 3;
   localparam int IDX_W10 = 4;
   localparam int IDX_W11 = 5;
   localparam int IDX_W20 = 6;
   localparam int IDX_W21 = 7;
   localparam int IDX_U00 = 8;
   localparam int IDX_U10 = 9;
   localparam int IDX_U20 = 10;

endpackage

// File: rtl/mlp_operand_loader.sv
// mlp_operand_loader: packs a serial stream of operand words into the named
//    operand registers of a small MLP and holds them until the consumer takes them.
// Latency: out_valid rises 1 cycle after the last word is accepted; 12-cycle min frame period.
// Backpressure: in_ready drops while a frame is held; held until out_valid && out_ready.
//
// Ports:
//    clk, rst_n            clock, synchronous active-low reset
//    in_valid/in_ready     upstream word handshake; in_data, in_last sampled on accept
//    x0..u20               registered operands, qualified by out_valid
//    out_valid/out_ready   frame handoff to the MLP datapath
//    frame_err             one-cycle pulse after a malformed frame is detected
//    frames_ok/frames_bad  presented-frame count (wraps) / malformed count (saturates)
module mlp_operand_loader #(
   parameter int DW      = mlp_pkg::DW,
   parameter int NUM_OPS = mlp_pkg::NUM_OPS,
   parameter int CNT_W   = mlp_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic             in_last,
   output logic [DW-1:0]    x0,
   output logic [DW-1:0]    x1,
   output logic [DW-1:0]    w00,
   output logic [DW-1:0]    w01,
   output logic [DW-1:0]    w10,
   output logic [DW-1:0]    w11,
   output logic [DW-1:0]    w20,
   output logic [DW-1:0]    w21,
   output logic [DW-1:0]    u00,
   output logic [DW-1:0]    u10,
   output logic [DW-1:0]    u20,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic [CNT_W-1:0] frames_ok,
   output logic [CNT_W-1:0] frames_bad
);

   import mlp_pkg::*;

   localparam int            IDX_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DW-1:0]    ops_q [NUM_OPS];
   logic             frame_err_q, err_d;
   logic [CNT_W-1:0] frames_ok_q, frames_bad_q;
   logic             ok_inc, bad_inc, wr_en, accept;

   assign in_ready  = (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid && in_ready;

   // Next-state / control decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      ok_inc  = 1'b0;
      bad_inc = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         LOAD: begin
            if (accept) begin
               // Every accepted word lands in its slot; a discarded partial
               // frame simply leaves stale data that out_valid never exposes.
               wr_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (in_last) begin
                     state_d = HOLD;
                     ok_inc  = 1'b1;
                  end else begin
                     // Frame overran its length: report once, then swallow
                     // words until the sender's own end marker.
                     state_d = DRAIN;
                     err_d   = 1'b1;
                     bad_inc = 1'b1;
                  end
               end else if (in_last) begin
                  idx_d   = '0;
                  err_d   = 1'b1;
                  bad_inc = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) state_d = LOAD;
         end
         DRAIN: begin
            if (accept && in_last) state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= LOAD;
         idx_q        <= '0;
         frame_err_q  <= 1'b0;
         frames_ok_q  <= '0;
         frames_bad_q <= '0;
         for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         frame_err_q <= err_d;
         if (wr_en) ops_q[idx_q] <= in_data;
         if (ok_inc) frames_ok_q <= frames_ok_q + CNT_W'(1);
         if (bad_inc && (frames_bad_q != '1)) frames_bad_q <= frames_bad_q + CNT_W'(1);
      end
   end

   assign frame_err  = frame_err_q;
   assign frames_ok  = frames_ok_q;
   assign frames_bad = frames_bad_q;

   assign x0  = ops_q[IDX_X0];
   assign x1  = ops_q[IDX_X1];
   assign w00 = ops_q[IDX_W00];
   assign w01 = ops_q[IDX_W01];
   assign w10 = ops_q[IDX_W10];
   assign w11 = ops_q[IDX_W11];
   assign w20 = ops_q[IDX_W20];
   assign w21 = ops_q[IDX_W21];
   assign u00 = ops_q[IDX_U00];
   assign u10 = ops_q[IDX_U10];
   assign u20 = ops_q[IDX_U20];

endmodule

// File: tb/tb_mlp_operand_loader.sv
// tb_mlp_operand_loader: directed bench for mlp_operand_loader.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: out_ready is held low during HOLD to test frame retention.
module tb_mlp_operand_loader;

   localparam int DW    = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, in_last;
   logic [DW-1:0]    in_data;
   logic [DW-1:0]    x0, x1, w00, w01, w10, w11, w20, w21, u00, u10, u20;
   logic             out_valid, out_ready, frame_err;
   logic [CNT_W-1:0] frames_ok, frames_bad;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;

   always #5 clk = ~clk;

   mlp_operand_loader dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .x0(x0), .x1(x1), .w00(w00), .w01(w01), .w10(w10), .w11(w11),
      .w20(w20), .w21(w21), .u00(u00), .u10(u10), .u20(u20),
      .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
      .frames_ok(frames_ok), .frames_bad(frames_bad)
   );

   // Whole operand set, x0 in the top bits, u20 in the bottom bits.
   logic [21:0] ops;
   assign ops = {x0, x1, w00, w01, w10, w11, w20, w21, u00, u10, u20};

   always @(negedge clk) if (rst_n && frame_err) err_pulses++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Present one word for exactly one rising edge; called and returns on a falling edge.
   task automatic drive(input logic [DW-1:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_good(input logic [21:0] f);
      for (int i = 0; i < 11; i++) drive(f[21-2*i -: 2], (i == 10));
   endtask

   task automatic release_frame();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // Hand-built frames (2-bit words, wire order x0..u20).
   localparam logic [21:0] FA = {2'd1,2'd2,2'd3,2'd0,2'd1,2'd2,2'd3,2'd0,2'd1,2'd2,2'd3}; // 22'h1B1B1B>>? see words
   localparam logic [21:0] FB = {2'd3,2'd3,2'd2,2'd2,2'd1,2'd1,2'd0,2'd0,2'd3,2'd2,2'd1};
   localparam logic [21:0] FC = {2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd0,2'd1,2'd2};
   localparam logic [21:0] FD = {2'd2,2'd0,2'd3,2'd1,2'd2,2'd0,2'd3,2'd1,2'd2,2'd0,2'd3};

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int unstable;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_frames_ok", 32'(frames_ok), 0);
      chk("rst_frames_bad", 32'(frames_bad), 0);
      chk("rst_ops", 32'(ops), 0);

      // Good frame: visible one cycle after the last accept
      for (int i = 0; i < 10; i++) drive(FA[21-2*i -: 2], 1'b0);
      chk("good_not_early", 32'(out_valid), 0);
      drive(FA[1:0], 1'b1);
      chk("good_out_valid", 32'(out_valid), 1);
      chk("good_x0", 32'(x0), 1);
      chk("good_u20", 32'(u20), 3);
      chk("good_ops", 32'(ops), 32'(FA));
      chk("good_frames_ok", 32'(frames_ok), 1);

      // Backpressure: offered words must not be taken while held
      unstable = 0;
      in_valid = 1'b1; in_data = 2'd0; in_last = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ops !== FA || in_ready !== 1'b0 || out_valid !== 1'b1) unstable++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("hold_stable", 32'(unstable), 0);
      chk("hold_frames_bad", 32'(frames_bad), 0);
      release_frame();
      chk("release_out_valid", 32'(out_valid), 0);
      chk("release_in_ready", 32'(in_ready), 1);
      chk("good_err_none", 32'(err_pulses), 0);

      // Short frame: end marker on word 5
      for (int i = 0; i < 4; i++) drive(2'(i), 1'b0);
      drive(2'd3, 1'b1);
      chk("short_err_pulse", 32'(frame_err), 1);
      chk("short_out_valid", 32'(out_valid), 0);
      chk("short_frames_bad", 32'(frames_bad), 1);
      send_good(FB);
      chk("short_next_ops", 32'(ops), 32'(FB));
      chk("short_next_ok", 32'(frames_ok), 2);
      chk("short_err_count", 32'(err_pulses), 1);
      release_frame();

      // Long frame: 14 words, end marker on word 14
      for (int i = 0; i < 11; i++) drive(FC[21-2*i -: 2] ^ 2'd3, 1'b0);
      chk("long_err_pulse", 32'(frame_err), 1);
      chk("long_drain_ready", 32'(in_ready), 1);
      drive(2'd1, 1'b0);
      chk("long_err_single", 32'(frame_err), 0);
      drive(2'd2, 1'b0);
      drive(2'd3, 1'b1);
      chk("long_out_valid", 32'(out_valid), 0);
      chk("long_frames_bad", 32'(frames_bad), 2);
      send_good(FC);
      chk("long_next_ops", 32'(ops), 32'(FC));
      chk("long_next_ok", 32'(frames_ok), 3);
      chk("long_err_count", 32'(err_pulses), 2);
      release_frame();

      // Reset mid-frame, after word 6
      for (int i = 0; i < 6; i++) drive(2'd3, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ops", 32'(ops), 0);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_frames_ok", 32'(frames_ok), 0);
      chk("midrst_frames_bad", 32'(frames_bad), 0);
      send_good(FD);
      chk("midrst_next_ops", 32'(ops), 32'(FD));
      chk("midrst_next_ok", 32'(frames_ok), 1);
      release_frame();

      // Counters: frames_ok wraps after 256, frames_bad saturates at 255
      for (int n = 0; n < 254; n++) begin
         send_good(FB);
         release_frame();
      end
      chk("ok_at_255", 32'(frames_ok), 255);
      send_good(FA);
      chk("ok_wrap", 32'(frames_ok), 0);
      chk("ok_wrap_ops", 32'(ops), 32'(FA));
      release_frame();
      for (int n = 0; n < 254; n++) drive(2'd1, 1'b1);
      chk("bad_at_254", 32'(frames_bad), 254);
      for (int n = 0; n < 46; n++) drive(2'd2, 1'b1);
      chk("bad_saturate", 32'(frames_bad), 255);
      send_good(FC);
      chk("after_bad_ops", 32'(ops), 32'(FC));
      chk("after_bad_ok", 32'(frames_ok), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
